div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The module SHALL have port dividend, input, WIDTH bits: signed two's-complement dividend, captured when start is accepted.
REQ-006 The module SHALL have port divisor, input, WIDTH bits: signed two's-complement divisor, captured when start is accepted.
REQ-007 The module SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-008 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 The module SHALL have port div_zero, output, 1 bit: one-cycle pulse, coincident with done, flagging a zero divisor.
REQ-010 The module SHALL have port hi, output, WIDTH bits: registered remainder, feeding the HI data input of the downstream result select mux.
REQ-011 The module SHALL have port lo, output, WIDTH bits: registered quotient, feeding the LO data input of the same mux.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 and divisor!=0, the block SHALL capture |dividend| and |divisor| as unsigned values, capture both sign bits, clear the partial remainder, load the iteration counter with WIDTH-1, and enter RUN.
REQ-014 In IDLE with start=1 and divisor==0, the block SHALL enter DONE directly, leave hi and lo unchanged, and assert div_zero with done.
REQ-015 In RUN, each cycle SHALL perform one restoring step: shift {remainder, quotient} left by 1; if remainder >= divisor, subtract the divisor and set the quotient LSB to 1.
REQ-016 The comparison and subtraction in each RUN step SHALL be WIDTH+1 bits wide, so that no overflow occurs.
REQ-017 RUN SHALL last exactly WIDTH cycles, after which the block enters DONE.
REQ-018 On entry to DONE from RUN, the block SHALL negate lo if the two sign bits differ and negate hi if the dividend was negative (remainder takes the sign of the dividend).
REQ-019 The sign-corrected results SHALL be registered into hi and lo on the edge that enters DONE.
REQ-020 DONE SHALL last exactly one cycle, with done=1, then return to IDLE.
REQ-021 Latency: done SHALL be high in the cycle beginning WIDTH+1 rising edges after the edge that accepted start (33 for WIDTH=32). For a zero divisor, done SHALL be high 1 edge after acceptance.
REQ-022 hi and lo SHALL hold their value from a completed division until the next completed division; they SHALL be valid in the done cycle.
REQ-023 A start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-024 A start asserted in the DONE cycle SHALL be ignored.
REQ-025 Most-negative dividend divided by -1 SHALL yield lo=most-negative value (wrap-around) and hi=0, with no flag raised.
REQ-026 Operand inputs SHALL be ignored outside the accepting cycle; changes during RUN SHALL NOT affect the result.

Reset
REQ-027 While reset=0, the block SHALL immediately force state=IDLE and busy=0, done=0, div_zero=0, hi=0, lo=0, and clear the counter and internal registers.
REQ-028 Reset asserted mid-RUN SHALL abort the operation, produce no done pulse, and leave hi=lo=0.
REQ-029 After reset deassertion, the block SHALL be ready to accept start on the first rising edge.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default width constant (32).
REQ-031 The block SHALL be a single module with one datapath and one FSM.
REQ-032 The combinational restoring step MAY be split into the sub-module div_step (inputs: remainder, quotient, divisor; outputs: next remainder, next quotient); no other sub-modules SHALL be used.

Verification
REQ-033 100 / 7 -> lo=14, hi=2; done high exactly 33 cycles after start; busy high throughout.
REQ-034 -7 / 2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); and 7 / -2 -> lo=-3, hi=1.
REQ-035 After a completed division leaves hi=5, lo=9, issuing 42 / 0 -> done=1 and div_zero=1 one cycle after start; hi=5, lo=9 unchanged.
REQ-036 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-037 Start 50/5, pulse start with 9/3 at cycle 10 of RUN -> single done; lo=10, hi=0; no second done follows.
REQ-038 Start 1000/3, assert reset at cycle 15 -> busy=0 and hi=lo=0 immediately; no done; a fresh 9/3 afterwards gives lo=3, hi=0.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential signed divider.
//   state_e   : FSM state encoding (IDLE / RUN / DONE)
//   DEF_WIDTH : default operand / result width
package div_seq_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/div_seq_step.sv
// One combinational restoring-division step on unsigned magnitudes.
//   rem_i / quo_i : current partial remainder and quotient/dividend shift register
//   dvs_i         : divisor magnitude
//   rem_o / quo_o : values after shifting left by one and conditionally subtracting
module div_step
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             ge;

  // Shift the next dividend bit into the remainder; compare on WIDTH+1 bits so
  // the shifted-out remainder MSB is never lost.
  always_comb begin
    trial = {rem_i, quo_i[WIDTH-1]};
    ge    = (trial >= {1'b0, dvs_i});
    // When trial >= divisor the true difference is below 2^WIDTH, so the low
    // WIDTH bits of the subtraction are exact.
    diff  = trial[WIDTH-1:0] - dvs_i;
    rem_o = ge ? diff : trial[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/div_seq.sv
// Sequential signed restoring divider, one quotient bit per clock.
//   clk, reset (async, active-low)
//   start, dividend, divisor : request; operands captured when start accepted in IDLE
//   busy     : high whenever not IDLE
//   done     : one-cycle completion pulse
//   div_zero : one-cycle pulse with done for a zero divisor
//   hi / lo  : registered remainder / quotient, held until the next completion
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            // Zero divisor: skip RUN, results untouched.
            state_d = DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            rem_d   = '0;
            quo_d   = dividend[WIDTH-1] ? WIDTH'('0 - dividend) : dividend;
            dvs_d   = divisor[WIDTH-1]  ? WIDTH'('0 - divisor)  : divisor;
            qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d  = dividend[WIDTH-1];
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = RUN;
          end
        end
      end

      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) begin
          // Last step: apply signs (remainder follows the dividend) and publish.
          state_d = DONE;
          done_d  = 1'b1;
          lo_d    = qneg_q ? WIDTH'('0 - step_quo) : step_quo;
          hi_d    = rneg_q ? WIDTH'('0 - step_rem) : step_rem;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  div_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a division is a countdown of W edges after the
  // accepting edge; results come from plain 64-bit signed arithmetic.
  int           m_cnt  = 0;
  bit           m_done = 1'b0;
  bit           m_dz   = 1'b0;
  logic [W-1:0] m_hi   = '0;
  logic [W-1:0] m_lo   = '0;
  logic [W-1:0] p_hi   = '0;
  logic [W-1:0] p_lo   = '0;

  initial begin
    bit     was_done;
    longint sa, sb, q, r;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_cnt = 0; m_done = 1'b0; m_dz = 1'b0; m_hi = '0; m_lo = '0;
      end else begin
        was_done = m_done;
        m_done   = 1'b0;
        m_dz     = 1'b0;
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) begin
            m_done = 1'b1;
            m_hi   = p_hi;
            m_lo   = p_lo;
          end
        end else if (!was_done && start) begin
          if (divisor == '0) begin
            m_done = 1'b1;
            m_dz   = 1'b1;
          end else begin
            sa = longint'($signed(dividend));
            sb = longint'($signed(divisor));
            q  = sa / sb;
            r  = sa - q * sb;
            p_lo  = W'(q);
            p_hi  = W'(r);
            m_cnt = W;
          end
        end
      end
    end
  end

  // Cycle-by-cycle compare of every output against the model.
  always @(negedge clk) begin
    chk("busy", W'(busy), W'((m_cnt > 0) || m_done));
    chk("done", W'(done), W'(m_done));
    chk("div_zero", W'(div_zero), W'(m_dz));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  // Issue one division and wait (bounded) for done; optionally pin results.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit noise,
                        input bit lit, input logic [W-1:0] e_lo, input logic [W-1:0] e_hi,
                        input bit e_dz, input int e_edges);
    int edges;
    bit got;
    @(posedge clk); #2;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #2;
    start = 1'b0;
    dividend = $urandom; divisor = $urandom;
    edges = 1;
    got   = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (lit) chk("busy_run", W'(busy), W'(1));
      @(posedge clk); #2;
      edges++;
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        dividend = $urandom; divisor = $urandom;
      end
    end
    chk("done_seen", W'(got), W'(1));
    if (lit) begin
      chk("latency", W'(edges), W'(e_edges));
      chk("lit_lo", lo, e_lo);
      chk("lit_hi", hi, e_hi);
      chk("lit_dz", W'(div_zero), W'(e_dz));
    end
    // Start held into the DONE cycle must be ignored.
    start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  initial begin
    int ndone;
    logic [W-1:0] a, b;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_lo", lo, '0);
    @(posedge clk); #2;
    reset = 1'b1;

    do_div(W'(100), W'(7), 1'b0, 1'b1, W'(14), W'(2), 1'b0, W + 1);
    do_div(W'(-7), W'(2), 1'b0, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, W + 1);
    do_div(W'(7), W'(-2), 1'b0, 1'b1, 32'hFFFF_FFFD, W'(1), 1'b0, W + 1);
    do_div(W'(59), W'(6), 1'b0, 1'b1, W'(9), W'(5), 1'b0, W + 1);
    do_div(W'(42), W'(0), 1'b0, 1'b1, W'(9), W'(5), 1'b1, 1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, W'(0), 1'b0, W + 1);

    // Start pulse with new operands mid-RUN is ignored; exactly one done.
    @(posedge clk); #2;
    start = 1'b1; dividend = W'(50); divisor = W'(5);
    @(posedge clk); #2;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 start = 1'b1; dividend = W'(9); divisor = W'(3);
    @(posedge clk); #2;
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("mid_lo", lo, W'(10));
        chk("mid_hi", hi, W'(0));
      end
    end
    chk("mid_ndone", W'(ndone), W'(1));

    // Reset mid-RUN aborts with outputs cleared, then a fresh division works.
    @(posedge clk); #2;
    start = 1'b1; dividend = W'(1000); divisor = W'(3);
    @(posedge clk); #2;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_hi", hi, '0);
    chk("abort_lo", lo, '0);
    @(posedge clk); #2;
    reset = 1'b1;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_ndone", W'(ndone), W'(0));
    do_div(W'(9), W'(3), 1'b0, 1'b1, W'(3), W'(0), 1'b0, W + 1);

    // Randomized divisions with start/operand noise; model checks every cycle.
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 9))
        0: begin a = $urandom; b = '0; end
        1: begin a = $urandom; b = W'($signed(6'($urandom))); end
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: begin a = W'($signed(8'($urandom))); b = $urandom; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      do_div(a, b, 1'b1, 1'b0, '0, '0, 1'b0, 0);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
